// File: rtl/unary_sqrt_sched.sv
// Round-robin scheduler sharing one unary sqrt kernel across NREQ binary requesters.
// Optional 4-cycle kernel warm-up before counting: define UNARY_SQRT_SCHED_WARMUP_EN.
module unary_sqrt_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               kern_in,
  output logic               kern_rst_n,
  input  logic               kern_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  x_q, x_d;
  logic [DW-1:0]  c_q, c_d;
  logic [DW:0]    ones_q, ones_d;
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
  logic [2:0]     warm_q, warm_d;
`endif

  logic           found;
  logic [IDW-1:0] gidx;
  int unsigned    idx;
  logic [DW-1:0]  c_rev;

  // Scan starting at the rr pointer, wrapping without a modulo operator.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < DW; b++) c_rev[b] = c_q[DW-1-b];
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    x_d        = x_q;
    c_d        = c_q;
    ones_d     = ones_q;
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
    warm_d     = warm_q;
`endif
    gnt        = '0;
    kern_in    = 1'b0;
    kern_rst_n = 1'b1;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_data   = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt[gidx] = 1'b1;
          x_d       = req_data[32'(gidx)*DW +: DW];
          id_d      = gidx;
          rr_d      = (32'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        kern_rst_n = 1'b0;
        c_d        = '0;
        ones_d     = '0;
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
        warm_d     = '0;
`endif
        state_d    = S_RUN;
      end
      S_RUN: begin
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
        if (warm_q != 3'd4) begin
          kern_in = (x_q != '0);
          warm_d  = warm_q + 3'd1;
        end else begin
          kern_in = (x_q > c_rev);
          ones_d  = ones_q + {{DW{1'b0}}, kern_out};
          c_d     = c_q + DW'(1);
          if (c_q == '1) state_d = S_RESP;
        end
`else
        kern_in = (x_q > c_rev);
        ones_d  = ones_q + {{DW{1'b0}}, kern_out};
        c_d     = c_q + DW'(1);
        if (c_q == '1) state_d = S_RESP;
`endif
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = ones_q[DW] ? '1 : ones_q[DW-1:0];
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset forces every output regardless of the registered state.
    if (rst) begin
      gnt        = '0;
      kern_in    = 1'b0;
      kern_rst_n = 1'b0;
      rsp_valid  = 1'b0;
      rsp_id     = '0;
      rsp_data   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      x_q     <= '0;
      c_q     <= '0;
      ones_q  <= '0;
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
      warm_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      c_q     <= c_d;
      ones_q  <= ones_d;
`ifdef UNARY_SQRT_SCHED_WARMUP_EN
      warm_q  <= warm_d;
`endif
    end
  end

endmodule

// File: doc/unary_sqrt_sched.md
Name: unary_sqrt_sched

Overview:
- Round-robin scheduler that time-shares one unary square-root kernel between NREQ binary-valued requesters.
- For each granted job, the scheduler:
  - clears the kernel's JK state;
  - converts the latched binary operand into a unipolar bitstream of 2^DW cycles;
  - drives that bitstream into the kernel;
  - counts the kernel's output ones.
- The count is returned as a binary result through a valid/ready response port, tagged with the requester id.
- It sits between the binary request fabric and the shared stochastic sqrt datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, operand/result width; one job's stream length is 2^DW cycles.
- IDW, 2, requester id width; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester request; held high until the matching gnt.
- req_data  in  NREQ*DW  per-requester operand; slice i belongs to req[i].
- gnt  out  NREQ  one-hot, single-cycle accept pulse.
- kern_in  out  1  bitstream bit driven to the kernel input.
- kern_rst_n  out  1  active-low clear to the kernel.
- kern_out  in  1  kernel output bit; combinational from kern_in and kernel state.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  DW  count of output ones, saturated.

Behaviour:
- Reset (rst=1): all outputs are forced on every cycle: gnt=0, kern_in=0, kern_rst_n=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - On reset, FSM=IDLE, rr pointer=0, stream counter=0, ones counter=0.
  - Reset mid-job aborts the job; the result is discarded and the requester is not re-granted automatically.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE (kern_rst_n=1, kern_in=0):
  - If any req is high, grant the first asserted index at or after the rr pointer, wrapping.
  - In the grant cycle: gnt[i]=1; latch req_data slice i as X and i as the id.
  - Set the rr pointer to (i+1) mod NREQ, then go to CLEAR.
- CLEAR: exactly 1 cycle. kern_rst_n=0, kern_in=0. Clear the stream counter C and the ones counter. Go to RUN.
- RUN: exactly 2^DW cycles, C = 0 .. 2^DW-1.
  - kern_rst_n=1.
  - kern_in = (X > bitrev(C)), where bitrev reverses the DW bits of C. Over the job, the number of ones in kern_in is exactly X.
  - Each RUN cycle, sample kern_out in the same cycle kern_in is driven; add it to the ones counter (DW+1 bits).
  - On the last cycle (C = 2^DW-1), go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_data = min(ones, 2^DW-1), i.e. a count of 2^DW saturates to all-ones.
  - rsp_id = latched id.
  - rsp_data and rsp_id are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid is 0 the next cycle.
- No grant is issued outside IDLE; requests arriving during CLEAR/RUN/RESP wait.
- Latency with grant in cycle t:
  - CLEAR in t+1;
  - RUN in t+2 .. t+1+2^DW;
  - rsp_valid first high in t+2+2^DW (t+258 for DW=8).
- Minimum spacing between grants is 2^DW+3 cycles (rsp_ready tied high).
- Simultaneous events: a req deassert in the grant cycle is ignored (the grant stands); rst has priority over everything.

Optional Feature:
- Macro: UNARY_SQRT_SCHED_WARMUP_EN.
- Defined: RUN is extended by 4 leading warm-up cycles.
  - C does not advance during warm-up.
  - kern_in = (X > 0) during warm-up.
  - kern_out is not counted during warm-up.
  - Latency becomes t+6+2^DW.
- Not defined: no warm-up; the latency above applies exactly.

Test Plan:
- rst high 3 cycles, then low, no req -> all outputs 0 except kern_rst_n=1 in IDLE; no gnt.
- req[0]=1, X=0 at cycle t -> gnt=4'b0001 in t only; kern_rst_n=0 in t+1; kern_in=0 for all 256 RUN cycles; rsp_valid in t+258 with rsp_id=0, rsp_data=0.
- req[1]=1, X=255 -> kern_in has 255 ones, with its single 0 at C=255; kern_out high all 256 cycles; rsp_data=255 (saturated), rsp_id=1.
- req=4'b1111 held, rsp_ready=1 -> gnt sequence 0,1,2,3,0, successive grants spaced 259 cycles; then with req=4'b0101 after grant 0 -> next grant 2, then 0.
- rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable all 10 cycles; no gnt despite pending req; IDLE one cycle after the handshake.
- rst pulsed at RUN cycle C=100 -> next cycle rsp_valid=0, kern_rst_n=0; after release, pending req[2] and req[3] -> gnt[2] first (rr pointer=0).
